channel_scanner: RTL and testbench
==================================

CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the width of the settle-count input.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a scan, honoured only in IDLE.
REQ-005 The block SHALL have port ch_mask, input, 4, the channels to scan (bit n = channel n).
REQ-006 The block SHALL have port dwell, input, DWELL_W, the extra settle cycles per channel.
REQ-007 The block SHALL have port mux_q, input, 1, the 4:1 selector output for the currently driven select.
REQ-008 The block SHALL have ports sel_0 and sel_1, output, 1 each, the select lines to the 4:1 selector (channel = {sel_1,sel_0}).
REQ-009 The block SHALL have port busy, output, 1, high in SETTLE and SAMPLE.
REQ-010 The block SHALL have port frame, output, 4, the captured sample per channel.
REQ-011 The block SHALL have port frame_valid, output, 1, high while frame is offered.
REQ-012 The block SHALL have port frame_ready, input, 1, the consumer accept.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and HOLD.
REQ-014 IDLE with start=1 and ch_mask!=0 SHALL latch ch_mask and dwell, clear frame to 0, select the lowest set mask bit, and enter SETTLE.
REQ-015 IDLE with start=1 and ch_mask=0 SHALL remain in IDLE with no output change.
REQ-016 SETTLE SHALL last exactly dwell+1 cycles (latched dwell), then enter SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle; on its closing edge mux_q SHALL be written to frame[current channel].
REQ-018 After SAMPLE the FSM SHALL enter SETTLE on the next higher set mask bit, or HOLD if none remains.
REQ-019 For N set mask bits, frame_valid SHALL rise exactly N*(dwell+2) edges after the edge that sampled start.
REQ-020 Unmasked frame bits SHALL read 0.
REQ-021 {sel_1,sel_0} SHALL equal the current channel in SETTLE and SAMPLE, hold the last channel in HOLD, and be 00 in IDLE.
REQ-022 In HOLD, frame_valid SHALL be 1 and frame SHALL be stable until a cycle with frame_ready=1; the next state SHALL then be IDLE with frame_valid=0.
REQ-023 frame_ready=1 in the first HOLD cycle SHALL be accepted, giving a single-cycle frame_valid.
REQ-024 start SHALL be ignored outside IDLE; ch_mask and dwell changes during a scan SHALL have no effect.
REQ-025 frame SHALL retain its value in IDLE until the next accepted start.

Reset
REQ-026 With rst=1 at an edge, from any state including mid-scan, the next cycle SHALL show state IDLE, sel_0=sel_1=0, busy=0, frame=0, frame_valid=0, and counters cleared.
REQ-027 rst SHALL take priority over start and frame_ready in the same cycle.

Structure
REQ-028 A package channel_scanner_pkg SHALL hold the state enumeration, NUM_CH=4 and SEL_W=2.
REQ-029 The next-channel search (lowest set mask bit above the current channel, plus a none-left flag) SHALL be a combinational sub-module next_channel_pick.

Verification
REQ-030 ch_mask=1111, dwell=0, selector model inputs in_3..in_0=1,0,1,0 -> sel steps 0,1,2,3 at 2 cycles each; frame_valid at edge 8 after start; frame=1010.
REQ-031 ch_mask=0101, dwell=2, all inputs 1 -> sel 0 for 4 cycles then 2 for 4 cycles; frame=0101; frame_valid at edge 8.
REQ-032 start with ch_mask=0000 -> busy and frame_valid stay 0; sel stays 00.
REQ-033 frame_ready held low for 5 HOLD cycles, with start pulsed during HOLD -> frame and sel stable, start ignored; IDLE one cycle after frame_ready=1.
REQ-034 rst pulsed while in SETTLE on channel 2 -> next cycle IDLE, sel 00, frame 0000, frame_valid 0; a following start scans normally.
REQ-035 ch_mask=1000, dwell=15 -> sel=11 throughout the scan; frame_valid at edge 17; frame[3]=in_3.

Source files
------------

// File: rtl/channel_scanner_pkg.sv
// Shared types and sizing for the channel scanner: FSM state encoding and channel geometry.
package channel_scanner_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StHold
  } state_e;

endpackage

// File: rtl/channel_scanner_next_channel_pick.sv
// Combinational search for the next channel to scan: lowest set mask bit above the current
// channel, or the lowest set bit overall when first_i is high.
module next_channel_pick
  import channel_scanner_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              first_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              none_o
);

  // Descending walk so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt_o  = '0;
    none_o = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        nxt_o  = SEL_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/channel_scanner.sv
// Scans the masked channels of a 4:1 selector, settling dwell+1 cycles per channel before
// sampling, then offers the captured frame until the consumer accepts it.
module channel_scanner
  import channel_scanner_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_q,
  output logic               sel_0,
  output logic               sel_1,
  output logic               busy,
  output logic [NUM_CH-1:0]  frame,
  output logic               frame_valid,
  input  logic               frame_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  frame_q, frame_d;

  logic [NUM_CH-1:0]  pick_mask;
  logic               pick_first;
  logic [SEL_W-1:0]   pick_nxt;
  logic               pick_none;

  // In IDLE the live mask is searched from bit 0; during a scan the latched mask is used.
  assign pick_first = (state_q == StIdle);
  assign pick_mask  = pick_first ? ch_mask : mask_q;

  next_channel_pick u_pick (
    .mask_i  (pick_mask),
    .cur_i   (ch_q),
    .first_i (pick_first),
    .nxt_o   (pick_nxt),
    .none_o  (pick_none)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (start && (|ch_mask)) begin
          mask_d  = ch_mask;
          dwell_d = dwell;
          frame_d = '0;
          ch_d    = pick_nxt;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == dwell_q) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        frame_d[ch_q] = mux_q;
        if (pick_none) begin
          state_d = StHold;
        end else begin
          ch_d    = pick_nxt;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StHold: begin
        if (frame_ready) begin
          ch_d    = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign sel_0       = ch_q[0];
  assign sel_1       = ch_q[1];
  assign busy        = (state_q == StSettle) || (state_q == StSample);
  assign frame       = frame_q;
  assign frame_valid = (state_q == StHold);

endmodule

// File: tb/tb_channel_scanner.sv
// Randomised and directed bench for channel_scanner against a schedule-based reference model.
module tb_channel_scanner;

  logic       clk = 1'b0;
  logic       rst, start, frame_ready;
  logic [3:0] ch_mask, frame, in_vec;
  logic [3:0] dwell;
  logic       mux_q, sel_0, sel_1, busy, frame_valid;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Selector model: in_vec[3..0] are in_3..in_0.
  assign mux_q = in_vec[{sel_1, sel_0}];

  channel_scanner #(.DWELL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_mask     (ch_mask),
    .dwell       (dwell),
    .mux_q       (mux_q),
    .sel_0       (sel_0),
    .sel_1       (sel_1),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a scan is a flat schedule of N*(dwell+2) cycles; cycle k belongs to the
  // k/(dwell+2)-th selected channel and the last cycle of each slot captures that input.
  bit         m_active = 0, m_hold = 0;
  int         m_chs[4];
  int         m_n, m_dw, m_pos, m_len, m_last;
  logic [3:0] m_frame = '0;

  always @(posedge clk) begin
    int c;
    if (rst) begin
      m_active = 0;
      m_hold   = 0;
      m_frame  = '0;
      m_last   = 0;
    end else if (m_hold) begin
      if (frame_ready) m_hold = 0;
    end else if (m_active) begin
      c = m_chs[m_pos / (m_dw + 2)];
      if (m_pos % (m_dw + 2) == m_dw + 1) m_frame[c] = in_vec[c];
      m_pos++;
      if (m_pos == m_len) begin
        m_active = 0;
        m_hold   = 1;
        m_last   = c;
      end
    end else if (start && ch_mask != 4'b0) begin
      m_n = 0;
      for (int i = 0; i < 4; i++) if (ch_mask[i]) begin m_chs[m_n] = i; m_n++; end
      m_dw     = int'(dwell);
      m_pos    = 0;
      m_len    = m_n * (m_dw + 2);
      m_active = 1;
      m_frame  = '0;
    end
  end

  always @(negedge clk) begin
    int exp_sel;
    if (chk_en) begin
      exp_sel = m_active ? m_chs[m_pos / (m_dw + 2)] : (m_hold ? m_last : 0);
      check("sel", {sel_1, sel_0}, exp_sel);
      check("busy", busy, m_active);
      check("frame_valid", frame_valid, m_hold);
      check("frame", frame, m_frame);
    end
  end

  // Start a scan, count edges to frame_valid, then leave it unaccepted for hold_cycles
  // (pulsing start each of those cycles) before accepting it.
  task automatic run_scan(input logic [3:0] mask, input logic [3:0] dw, input logic [3:0] inv,
                          input int exp_edges, input logic [3:0] exp_frame,
                          input int hold_cycles, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; ch_mask = mask; dwell = dw; in_vec = inv; frame_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ch_mask = 4'($urandom); dwell = 4'($urandom);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (frame_valid) break;
    end
    check({tag, "_edges"}, n, exp_edges);
    check({tag, "_frame"}, frame, exp_frame);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      start = 1'b1; ch_mask = 4'b1111;
    end
    if (hold_cycles > 0) begin
      #1;
      check({tag, "_hold_valid"}, frame_valid, 1'b1);
      check({tag, "_hold_frame"}, frame, exp_frame);
    end
    @(negedge clk);
    start = 1'b0; frame_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_acc_valid"}, frame_valid, 1'b0);
    check({tag, "_acc_sel"}, {sel_1, sel_0}, 2'b00);
    check({tag, "_keep_frame"}, frame, exp_frame);
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; frame_ready = 1'b0; ch_mask = '0; dwell = '0; in_vec = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_frame", frame, 4'b0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    run_scan(4'b1111, 4'd0, 4'b1010, 8, 4'b1010, 0, "all_d0");
    run_scan(4'b0101, 4'd2, 4'b1111, 8, 4'b0101, 0, "m0101_d2");
    run_scan(4'b0110, 4'd1, 4'b1111, 6, 4'b0110, 5, "hold5");
    run_scan(4'b1000, 4'd15, 4'b1000, 17, 4'b1000, 0, "ch3_d15");
    run_scan(4'b1000, 4'd15, 4'b0111, 17, 4'b0000, 1, "ch3_zero");

    // Empty mask: nothing starts.
    @(negedge clk);
    start = 1'b1; ch_mask = 4'b0000; dwell = 4'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("empty_busy", busy, 1'b0);
    check("empty_valid", frame_valid, 1'b0);
    check("empty_sel", {sel_1, sel_0}, 2'b00);

    // Reset while settling on channel 2.
    @(negedge clk);
    start = 1'b1; ch_mask = 4'b0100; dwell = 4'd5; in_vec = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && {sel_1, sel_0} == 2'b10) && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_reach", n < 50, 1'b1);
    rst = 1'b1; start = 1'b1; frame_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; frame_ready = 1'b0;
    check("rst_mid_sel", {sel_1, sel_0}, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_frame", frame, 4'b0000);
    check("rst_mid_valid", frame_valid, 1'b0);
    run_scan(4'b1001, 4'd1, 4'b1001, 6, 4'b1001, 0, "after_rst");

    // Randomised phase: every input may toggle every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start       = ($urandom_range(3) == 0);
      ch_mask     = 4'($urandom);
      dwell       = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(2));
      frame_ready = ($urandom_range(2) == 0);
      in_vec      = 4'($urandom);
      rst         = ($urandom_range(150) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
